// File: rtl/vault_code_checker.sv
// Vault code checker: collects CODE_LEN symbols over valid/ready, compares them against code_key,
// and tracks an attempt budget with an inter-symbol timeout. VAULT_LOCKOUT_EN makes FAIL timed.
module vault_code_checker #(
   parameter int SYM_W       = 4,
   parameter int CODE_LEN    = 4,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 1024,
   parameter int LOCKOUT_CYC = 4096
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SYM_W-1:0]              sym_in,
   input  logic                          sym_valid,
   output logic                          sym_ready,
   input  logic [SYM_W*CODE_LEN-1:0]     code_key,
   input  logic                          clear,
   output logic                          done,
   output logic                          fail,
   output logic                          attempt_bad,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
   output logic                          busy
);

   localparam int IDX_W  = $clog2(CODE_LEN+1);
   localparam int TCNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC+1) : 1;
   localparam int TRY_W  = $clog2(MAX_TRIES+1);

   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(CODE_LEN-1);
   localparam logic [TCNT_W-1:0] TO_LAST    = TCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC-1 : 0);
   localparam logic [TRY_W-1:0]  TRIES_INIT = TRY_W'(MAX_TRIES);

   if (MAX_TRIES < 1 || CODE_LEN < 1 || SYM_W < 1 || TIMEOUT_CYC < 0 || LOCKOUT_CYC < 1) begin : g_param_check
      $error("vault_code_checker: illegal parameter value");
   end

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_FAIL} state_t;

   state_t            state, state_nx;
   logic [IDX_W-1:0]  idx, idx_nx;
   logic              mis, mis_nx;
   logic [TCNT_W-1:0] tcnt, tcnt_nx;
   logic [TRY_W-1:0]  tries, tries_nx;
   logic              bad_q, bad_nx;
   logic [SYM_W-1:0]  key_sym;
   logic              accept, mis_now, timeout_hit, fail_attempt;

`ifdef VAULT_LOCKOUT_EN
   localparam int LCNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCKOUT_CYC-1);

   logic [LCNT_W-1:0] lcnt, lcnt_nx;
   logic              lock_expire;

   assign lcnt_nx     = (state == S_FAIL) ? lcnt + LCNT_W'(1) : '0;
   assign lock_expire = (state == S_FAIL) && (lcnt == LOCK_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lcnt <= '0;
      else       lcnt <= lcnt_nx;
   end
`endif

   // Handshake: a symbol transfers on a rising edge with sym_valid && sym_ready; sym_ready is a pure
   // state decode (IDLE/COLLECT), so symbols offered in DONE/FAIL are simply dropped.
   assign sym_ready   = (state == S_IDLE) || (state == S_COLLECT);
   assign done        = (state == S_DONE);
   assign fail        = (state == S_FAIL);
   assign busy        = (state == S_COLLECT);
   assign attempt_bad = bad_q;
   assign tries_left  = tries;

   always_comb begin
      key_sym = '0;
      for (int k = 0; k < CODE_LEN; k++) begin
         if (idx == IDX_W'(k)) key_sym = code_key[k*SYM_W +: SYM_W];
      end
   end

   assign accept      = sym_valid && sym_ready;
   assign mis_now     = mis || (sym_in != key_sym);
   assign timeout_hit = (TIMEOUT_CYC > 0) && (state == S_COLLECT) && !accept && (tcnt == TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         idx   <= '0;
         mis   <= 1'b0;
         tcnt  <= '0;
         tries <= TRIES_INIT;
         bad_q <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         mis   <= mis_nx;
         tcnt  <= tcnt_nx;
         tries <= tries_nx;
         bad_q <= bad_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      mis_nx       = mis;
      tcnt_nx      = tcnt;
      tries_nx     = tries;
      bad_nx       = 1'b0;
      fail_attempt = 1'b0;
      case (state)
         S_IDLE, S_COLLECT: begin
            // clear outranks a symbol, a timeout and the verdict on the same edge
            if (clear) begin
               state_nx = S_IDLE;
               idx_nx   = '0;
               mis_nx   = 1'b0;
               tcnt_nx  = '0;
            end else if (accept) begin
               tcnt_nx = '0;
               if (idx == LAST_IDX) begin
                  idx_nx = '0;
                  mis_nx = 1'b0;
                  if (mis_now) fail_attempt = 1'b1;
                  else         state_nx     = S_DONE;
               end else begin
                  state_nx = S_COLLECT;
                  idx_nx   = idx + IDX_W'(1);
                  mis_nx   = mis_now;
               end
            end else if (timeout_hit) begin
               fail_attempt = 1'b1;
            end else if (state == S_COLLECT && TIMEOUT_CYC > 0) begin
               tcnt_nx = tcnt + TCNT_W'(1);
            end
            if (fail_attempt) begin
               bad_nx  = 1'b1;
               idx_nx  = '0;
               mis_nx  = 1'b0;
               tcnt_nx = '0;
               if (tries <= TRY_W'(1)) begin
                  tries_nx = '0;
                  state_nx = S_FAIL;
               end else begin
                  tries_nx = tries - TRY_W'(1);
                  state_nx = S_IDLE;
               end
            end
         end
         S_DONE: begin
            if (clear) begin
               state_nx = S_IDLE;
               tries_nx = TRIES_INIT;
            end
         end
         S_FAIL: begin
`ifdef VAULT_LOCKOUT_EN
            if (lock_expire) begin
               state_nx = S_IDLE;
               tries_nx = TRIES_INIT;
            end
`else
            state_nx = S_FAIL;
`endif
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_vault_code_checker.sv
// Directed bench for vault_code_checker: table of whole-code entries plus hand sequences for
// timeout, clear priority, reset and FAIL behaviour (timed FAIL when VAULT_LOCKOUT_EN is defined).
module tb_vault_code_checker;

   localparam int SYM_W       = 4;
   localparam int CODE_LEN    = 4;
   localparam int MAX_TRIES   = 3;
   localparam int TIMEOUT_CYC = 16;
   localparam int LOCKOUT_CYC = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  sym_in;
   logic        sym_valid;
   logic        sym_ready;
   logic [15:0] code_key;
   logic        clear;
   logic        done;
   logic        fail;
   logic        attempt_bad;
   logic [1:0]  tries_left;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;
   logic [6:0] exp_q[$];

   typedef struct {
      logic [15:0] syms;
      logic        e_done;
      logic        e_fail;
      logic        e_bad;
      logic        e_ready;
      logic [1:0]  e_tries;
   } vec_t;

   vec_t vecs[6];

   vault_code_checker #(
      .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES),
      .TIMEOUT_CYC(TIMEOUT_CYC), .LOCKOUT_CYC(LOCKOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .code_key(code_key), .clear(clear), .done(done), .fail(fail), .attempt_bad(attempt_bad),
      .tries_left(tries_left), .busy(busy)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // driver tasks: every task returns 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] s, input logic clr);
      sym_in    = s;
      sym_valid = 1'b1;
      clear     = clr;
      tick();
      sym_valid = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic enter(input logic [15:0] s);
      for (int k = 0; k < 4; k++) send(s[k*4 +: 4], 1'b0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // scoreboard
   task automatic expect_status(input string name, input logic e_done, input logic e_fail,
                                input logic e_bad, input logic e_ready, input logic e_busy,
                                input logic [1:0] e_tries);
      logic [6:0] act, exp;
      exp_q.push_back({e_done, e_fail, e_bad, e_ready, e_busy, e_tries});
      act = {done, fail, attempt_bad, sym_ready, busy, tries_left};
      exp = exp_q.pop_front();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: done/fail/bad/ready/busy/tries got %b want %b", name, act, exp);
      end
   endtask

   task automatic expect_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   initial begin
      logic [15:0] s;
      logic [1:0]  cur_tries;
      int          cnt;

      // entries from reset: wrong, right, right, wrong first symbol, all zero, reversed order
      vecs[0] = '{16'h2B3A, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[1] = '{16'h1B3A, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
      vecs[2] = '{16'h1B3A, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
      vecs[3] = '{16'h1B3B, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2};
      vecs[4] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
      vecs[5] = '{16'hA3B1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};

      reset     = 1'b1;
      sym_in    = '0;
      sym_valid = 1'b0;
      clear     = 1'b0;
      code_key  = 16'h1B3A;
      repeat (2) tick();
      expect_status("reset_held", 0, 0, 0, 1, 0, 2'd3);
      reset = 1'b0;
      tick();
      expect_status("reset_released", 0, 0, 0, 1, 0, 2'd3);

      cur_tries = 2'd3;
      for (int i = 0; i < 6; i++) begin
         s = vecs[i].syms;
         for (int k = 0; k < 4; k++) begin
            send(s[k*4 +: 4], 1'b0);
            if (k < 3) expect_status($sformatf("vec%0d_sym%0d", i, k), 0, 0, 0, 1, 1, cur_tries);
         end
         expect_status($sformatf("vec%0d_verdict", i), vecs[i].e_done, vecs[i].e_fail,
                       vecs[i].e_bad, vecs[i].e_ready, 1'b0, vecs[i].e_tries);
         tick();
         expect_status($sformatf("vec%0d_after", i), vecs[i].e_done, vecs[i].e_fail,
                       1'b0, vecs[i].e_ready, 1'b0, vecs[i].e_tries);
         cur_tries = vecs[i].e_tries;
         if (vecs[i].e_done) begin
            pulse_clear();
            expect_status($sformatf("vec%0d_clear", i), 0, 0, 0, 1, 0, 2'd3);
            cur_tries = 2'd3;
         end
      end

      // FAIL ignores symbols and clear
      enter(16'h1B3A);
      send(4'hA, 1'b1);
      expect_status("fail_sticky", 0, 1, 0, 0, 0, 2'd0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_status("fail_reset", 0, 0, 0, 1, 0, 2'd3);

      // inter-symbol timeout after A,3
      send(4'hA, 1'b0);
      send(4'h3, 1'b0);
      repeat (15) tick();
      expect_status("timeout_pending", 0, 0, 0, 1, 1, 2'd3);
      tick();
      expect_status("timeout_abort", 0, 0, 1, 1, 0, 2'd2);
      tick();
      expect_status("timeout_pulse_end", 0, 0, 0, 1, 0, 2'd2);

      // symbol on the expiry cycle wins
      send(4'hA, 1'b0);
      send(4'h3, 1'b0);
      repeat (15) tick();
      send(4'hB, 1'b0);
      expect_status("expiry_symbol", 0, 0, 0, 1, 1, 2'd2);
      send(4'h1, 1'b0);
      expect_status("expiry_done", 1, 0, 0, 0, 0, 2'd2);
      send(4'hA, 1'b0);
      send(4'h3, 1'b0);
      expect_status("done_drops_syms", 1, 0, 0, 0, 0, 2'd2);
      pulse_clear();
      expect_status("done_clear", 0, 0, 0, 1, 0, 2'd3);

      // clear beats a symbol and the verdict
      send(4'hA, 1'b0);
      send(4'h3, 1'b0);
      send(4'hB, 1'b1);
      expect_status("clear_vs_sym", 0, 0, 0, 1, 0, 2'd3);
      send(4'hA, 1'b0);
      send(4'h3, 1'b0);
      send(4'hB, 1'b0);
      send(4'h2, 1'b1);
      expect_status("clear_vs_verdict", 0, 0, 0, 1, 0, 2'd3);
      tick();
      expect_status("clear_vs_verdict_next", 0, 0, 0, 1, 0, 2'd3);
      enter(16'h1B3A);
      expect_status("after_clear_entry", 1, 0, 0, 0, 0, 2'd3);
      pulse_clear();

      // asynchronous reset mid-entry
      enter(16'h2B3A);
      expect_status("pre_reset_wrong", 0, 0, 1, 1, 0, 2'd2);
      send(4'hA, 1'b0);
      send(4'h3, 1'b0);
      expect_status("pre_reset_partial", 0, 0, 0, 1, 1, 2'd2);
      #4 reset = 1'b1;
      #1 expect_status("async_reset", 0, 0, 0, 1, 0, 2'd3);
      @(posedge clk);
      #1 reset = 1'b0;

      enter(16'h0000);
      enter(16'h0000);
      enter(16'h0000);
      expect_status("exhaust", 0, 1, 1, 0, 0, 2'd0);
`ifdef VAULT_LOCKOUT_EN
      cnt = 1;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (fail) cnt++;
         else break;
      end
      expect_int("lockout_len", cnt, LOCKOUT_CYC);
      expect_status("lockout_end", 0, 0, 0, 1, 0, 2'd3);
      enter(16'h1B3A);
      expect_status("lockout_then_done", 1, 0, 0, 0, 0, 2'd3);
`else
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (fail) cnt++;
      end
      expect_int("fail_permanent_len", cnt, 40);
      expect_status("fail_permanent", 0, 1, 0, 0, 0, 2'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
